// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-port types for the cache/memory arbiter slice.
package mem_port_arbiter_pkg;
    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } MEM_COMMAND;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } MEM_OWNER;

    localparam int DEF_NUM_MEM_TAGS = 15;
    localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/mem_tag_table.sv
// Ownership table for in-flight memory loads: allocate on accept, look up and free on response.
module mem_tag_table
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_MEM_TAGS = DEF_NUM_MEM_TAGS
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       alloc_en,
    input  MEM_TAG     alloc_tag,
    input  MEM_OWNER   alloc_owner,
    input  MEM_TAG     lookup_tag,
    output logic       lookup_hit,
    output MEM_OWNER   lookup_owner,
    output logic [3:0] count,
    output logic       error
);
    logic     valid [1:NUM_MEM_TAGS];
    MEM_OWNER owner [1:NUM_MEM_TAGS];
    logic     alloc_busy;
    logic     table_err;

    always_comb begin
        lookup_hit   = 1'b0;
        lookup_owner = OWN_ICACHE;
        alloc_busy   = 1'b0;
        for (int unsigned t = 1; t <= NUM_MEM_TAGS; t++) begin
            if (lookup_tag == MEM_TAG'(t) && valid[t]) begin
                lookup_hit   = 1'b1;
                lookup_owner = owner[t];
            end
            if (alloc_tag == MEM_TAG'(t) && valid[t])
                alloc_busy = 1'b1;
        end
        // A tag freed this cycle may be reallocated without counting as a clash
        if (lookup_hit && lookup_tag == alloc_tag)
            alloc_busy = 1'b0;
        table_err = (lookup_tag != '0 && !lookup_hit) || (alloc_en && alloc_busy);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned t = 1; t <= NUM_MEM_TAGS; t++) begin
                valid[t] <= 1'b0;
                owner[t] <= OWN_ICACHE;
            end
            count <= '0;
            error <= 1'b0;
        end else begin
            // Free is written before allocate so a same-tag allocate wins
            for (int unsigned t = 1; t <= NUM_MEM_TAGS; t++) begin
                if (lookup_hit && lookup_tag == MEM_TAG'(t))
                    valid[t] <= 1'b0;
                if (alloc_en && alloc_tag == MEM_TAG'(t)) begin
                    valid[t] <= 1'b1;
                    owner[t] <= alloc_owner;
                end
            end
            count <= count + 4'(alloc_en && !alloc_busy) - 4'(lookup_hit);
            if (table_err)
                error <= 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the processor-memory port between icache and dcache miss paths and routes tagged responses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_MEM_TAGS = DEF_NUM_MEM_TAGS,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_accept,
    output logic        i_resp_valid,
    output logic [3:0]  i_resp_tag,
    input  logic        d_req_valid,
    input  logic [1:0]  d_req_cmd,
    input  logic [31:0] d_req_addr,
    input  logic [63:0] d_req_data,
    output logic        d_accept,
    output logic        d_resp_valid,
    output logic [3:0]  d_resp_tag,
    output logic [3:0]  req_tag,
    output logic [63:0] resp_data,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_transaction_tag,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_data_tag,
    output logic [3:0]  outstanding,
    output logic        tag_error
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       [3:0] starve_cnt;
    logic             i_win, d_win, accepted, load_alloc, resp_hit;
    MEM_COMMAND       cmd;
    MEM_OWNER         alloc_owner, resp_owner;

    always_comb begin
        i_win         = i_req_valid && (!d_req_valid || starve_cnt >= LIMIT);
        d_win         = d_req_valid && !i_win;
        cmd           = BUS_NONE;
        proc2mem_addr = '0;
        proc2mem_data = '0;
        if (i_win) begin
            cmd           = BUS_LOAD;
            proc2mem_addr = i_req_addr;
        end else if (d_win) begin
            cmd           = MEM_COMMAND'(d_req_cmd);
            proc2mem_addr = d_req_addr;
            proc2mem_data = d_req_data;
        end
        proc2mem_command = cmd;
        accepted    = (i_win || d_win) && mem2proc_transaction_tag != '0;
        i_accept    = i_win && accepted;
        d_accept    = d_win && accepted;
        req_tag     = accepted ? mem2proc_transaction_tag : '0;
        load_alloc  = accepted && cmd == BUS_LOAD;
        alloc_owner = i_win ? OWN_ICACHE : OWN_DCACHE;

        i_resp_valid = resp_hit && resp_owner == OWN_ICACHE;
        d_resp_valid = resp_hit && resp_owner == OWN_DCACHE;
        i_resp_tag   = i_resp_valid ? mem2proc_data_tag : '0;
        d_resp_tag   = d_resp_valid ? mem2proc_data_tag : '0;
        resp_data    = mem2proc_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (i_req_valid && !i_win)
            starve_cnt <= (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
        else
            starve_cnt <= '0;
    end

    mem_tag_table #(
        .NUM_MEM_TAGS(NUM_MEM_TAGS)
    ) u_tag_table (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (load_alloc),
        .alloc_tag    (mem2proc_transaction_tag),
        .alloc_owner  (alloc_owner),
        .lookup_tag   (mem2proc_data_tag),
        .lookup_hit   (resp_hit),
        .lookup_owner (resp_owner),
        .count        (outstanding),
        .error        (tag_error)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a tag-map reference model checked every cycle.
module tb_mem_port_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int NUM_MEM_TAGS = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_accept, i_resp_valid;
    logic [3:0]  i_resp_tag;
    logic        d_req_valid;
    logic [1:0]  d_req_cmd;
    logic [31:0] d_req_addr;
    logic [63:0] d_req_data;
    logic        d_accept, d_resp_valid;
    logic [3:0]  d_resp_tag, req_tag;
    logic [63:0] resp_data;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;
    logic [3:0]  outstanding;
    logic        tag_error;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(
        .NUM_MEM_TAGS(NUM_MEM_TAGS),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_accept(i_accept),
        .i_resp_valid(i_resp_valid), .i_resp_tag(i_resp_tag),
        .d_req_valid(d_req_valid), .d_req_cmd(d_req_cmd), .d_req_addr(d_req_addr),
        .d_req_data(d_req_data), .d_accept(d_accept), .d_resp_valid(d_resp_valid),
        .d_resp_tag(d_resp_tag), .req_tag(req_tag), .resp_data(resp_data),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data), .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
        .outstanding(outstanding), .tag_error(tag_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tag -> {valid, owner(0=icache,1=dcache)}, lost-cycle run, sticky error
    bit          mv [16];
    int          mo [16];
    int          lost;
    bit          merr;
    bit          m_iw, m_dw, m_acc, m_hit;
    int          m_cmd, m_cnt;
    logic [31:0] m_addr;
    logic [63:0] m_data;

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mv[i] = 1'b0;
            lost = 0;
            merr = 1'b0;
            check("rst_cmd", 64'(proc2mem_command), 64'd0);
            check("rst_addr", 64'(proc2mem_addr), 64'd0);
            check("rst_data", proc2mem_data, 64'd0);
            check("rst_accepts", {62'd0, i_accept, d_accept}, 64'd0);
            check("rst_resp", {62'd0, i_resp_valid, d_resp_valid}, 64'd0);
            check("rst_req_tag", 64'(req_tag), 64'd0);
            check("rst_outstanding", 64'(outstanding), 64'd0);
            check("rst_tag_error", 64'(tag_error), 64'd0);
        end else begin
            m_cnt = 0;
            for (int i = 0; i < 16; i++) m_cnt += int'(mv[i]);
            check("outstanding", 64'(outstanding), 64'(m_cnt));
            check("tag_error", 64'(tag_error), 64'(merr));

            m_iw = i_req_valid && (!d_req_valid || lost >= STARVE_LIMIT);
            m_dw = d_req_valid && !m_iw;
            m_cmd = m_iw ? 1 : (m_dw ? int'(d_req_cmd) : 0);
            m_addr = m_iw ? i_req_addr : (m_dw ? d_req_addr : 32'd0);
            m_data = m_dw ? d_req_data : 64'd0;
            m_acc = (m_iw || m_dw) && mem2proc_transaction_tag != 4'd0;
            m_hit = mem2proc_data_tag != 4'd0 && mv[mem2proc_data_tag];

            check("command", 64'(proc2mem_command), 64'(m_cmd));
            check("addr", 64'(proc2mem_addr), 64'(m_addr));
            check("data", proc2mem_data, m_data);
            check("i_accept", 64'(i_accept), 64'(m_iw && m_acc));
            check("d_accept", 64'(d_accept), 64'(m_dw && m_acc));
            check("req_tag", 64'(req_tag), m_acc ? 64'(mem2proc_transaction_tag) : 64'd0);
            check("i_resp_valid", 64'(i_resp_valid), 64'(m_hit && mo[mem2proc_data_tag] == 0));
            check("d_resp_valid", 64'(d_resp_valid), 64'(m_hit && mo[mem2proc_data_tag] == 1));
            check("i_resp_tag", 64'(i_resp_tag),
                  (m_hit && mo[mem2proc_data_tag] == 0) ? 64'(mem2proc_data_tag) : 64'd0);
            check("d_resp_tag", 64'(d_resp_tag),
                  (m_hit && mo[mem2proc_data_tag] == 1) ? 64'(mem2proc_data_tag) : 64'd0);
            check("resp_data", resp_data, mem2proc_data);

            // Next state, as committed at the coming edge
            if (mem2proc_data_tag != 4'd0 && !m_hit) merr = 1'b1;
            if (m_hit) mv[mem2proc_data_tag] = 1'b0;
            if (m_acc && m_cmd == 1) begin
                if (mv[mem2proc_transaction_tag]) merr = 1'b1;
                mv[mem2proc_transaction_tag] = 1'b1;
                mo[mem2proc_transaction_tag] = m_iw ? 0 : 1;
            end
            if (i_req_valid && !m_iw) lost = (lost < 15) ? lost + 1 : 15;
            else lost = 0;
        end
    end

    task automatic clr();
        i_req_valid = 0; i_req_addr = '0;
        d_req_valid = 0; d_req_cmd = 2'd0; d_req_addr = '0; d_req_data = '0;
        mem2proc_transaction_tag = '0; mem2proc_data = '0; mem2proc_data_tag = '0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, elapsed %0t required below 200000", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        clr();
        cyc(); cyc();
        @(negedge clock);
        check("lit_reset_cmd", 64'(proc2mem_command), 64'd0);
        cyc();
        reset = 1'b1;

        // icache-only load, tag 3, then its response
        i_req_valid = 1; i_req_addr = 32'h100; mem2proc_transaction_tag = 4'd3;
        @(negedge clock);
        check("lit_i_accept", 64'(i_accept), 64'd1);
        check("lit_req_tag3", 64'(req_tag), 64'd3);
        check("lit_addr100", 64'(proc2mem_addr), 64'h100);
        cyc(); clr();
        @(negedge clock);
        check("lit_outst1", 64'(outstanding), 64'd1);
        cyc();
        mem2proc_data_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0123_4567;
        @(negedge clock);
        check("lit_i_resp_valid", 64'(i_resp_valid), 64'd1);
        check("lit_i_resp_tag", 64'(i_resp_tag), 64'd3);
        cyc(); clr();
        @(negedge clock);
        check("lit_outst0", 64'(outstanding), 64'd0);

        // rejected with tag 0, retried with tag 2
        cyc();
        i_req_valid = 1; i_req_addr = 32'h200; mem2proc_transaction_tag = 4'd0;
        @(negedge clock);
        check("lit_reject", 64'(i_accept), 64'd0);
        cyc();
        mem2proc_transaction_tag = 4'd2;
        @(negedge clock);
        check("lit_retry", 64'(i_accept), 64'd1);
        cyc(); clr();
        @(negedge clock);
        check("lit_retry_outst", 64'(outstanding), 64'd1);
        cyc();
        mem2proc_data_tag = 4'd2;
        cyc(); clr();

        // dcache load tag 4, then its response while icache takes tag 4
        d_req_valid = 1; d_req_cmd = 2'd1; d_req_addr = 32'h400; mem2proc_transaction_tag = 4'd4;
        cyc(); clr();
        i_req_valid = 1; i_req_addr = 32'h500; mem2proc_transaction_tag = 4'd4;
        mem2proc_data_tag = 4'd4; mem2proc_data = 64'h44;
        @(negedge clock);
        check("lit_swap_d_resp", 64'(d_resp_valid), 64'd1);
        check("lit_swap_d_tag", 64'(d_resp_tag), 64'd4);
        check("lit_swap_i_acc", 64'(i_accept), 64'd1);
        cyc(); clr();
        @(negedge clock);
        check("lit_swap_outst", 64'(outstanding), 64'd1);
        check("lit_swap_err", 64'(tag_error), 64'd0);
        cyc();
        mem2proc_data_tag = 4'd4;
        @(negedge clock);
        check("lit_swap_owner_i", 64'(i_resp_valid), 64'd1);
        cyc(); clr();

        // both request every cycle, tag 5 reused and freed in the same cycle
        for (int k = 0; k < 10; k++) begin
            i_req_valid = 1; i_req_addr = 32'h600;
            d_req_valid = 1; d_req_cmd = 2'd1; d_req_addr = 32'h700; d_req_data = 64'(k);
            mem2proc_transaction_tag = 4'd5;
            mem2proc_data_tag = (k == 0) ? 4'd0 : 4'd5;
            @(negedge clock);
            check("lit_starve_i", 64'(i_accept), 64'((k % 5) == 4));
            check("lit_starve_d", 64'(d_accept), 64'((k % 5) != 4));
            cyc();
        end
        clr();
        @(negedge clock);
        check("lit_starve_outst", 64'(outstanding), 64'd1);
        cyc();
        mem2proc_data_tag = 4'd5;
        cyc(); clr();

        // store accepted with tag 7 leaves no entry; its stray response is an error
        d_req_valid = 1; d_req_cmd = 2'd2; d_req_addr = 32'h800; d_req_data = 64'hCAFE_F00D;
        mem2proc_transaction_tag = 4'd7;
        @(negedge clock);
        check("lit_store_acc", 64'(d_accept), 64'd1);
        check("lit_store_data", proc2mem_data, 64'hCAFE_F00D);
        cyc(); clr();
        @(negedge clock);
        check("lit_store_outst", 64'(outstanding), 64'd0);
        cyc();
        mem2proc_data_tag = 4'd7;
        @(negedge clock);
        check("lit_store_drop", 64'(d_resp_valid), 64'd0);
        cyc(); clr();
        @(negedge clock);
        check("lit_store_err", 64'(tag_error), 64'd1);

        // reset pulse, then reset mid-traffic with two loads in flight
        cyc();
        reset = 1'b0;
        @(negedge clock);
        check("lit_err_cleared", 64'(tag_error), 64'd0);
        cyc();
        reset = 1'b1;
        i_req_valid = 1; i_req_addr = 32'h900; mem2proc_transaction_tag = 4'd1;
        cyc(); clr();
        d_req_valid = 1; d_req_cmd = 2'd1; d_req_addr = 32'hA00; mem2proc_transaction_tag = 4'd6;
        cyc(); clr();
        @(negedge clock);
        check("lit_two_inflight", 64'(outstanding), 64'd2);
        cyc();
        reset = 1'b0;
        #1;
        check("lit_async_outst", 64'(outstanding), 64'd0);
        check("lit_async_cmd", 64'(proc2mem_command), 64'd0);
        cyc();
        reset = 1'b1;
        mem2proc_data_tag = 4'd1;
        @(negedge clock);
        check("lit_post_rst_drop", 64'(i_resp_valid), 64'd0);
        cyc();
        mem2proc_data_tag = 4'd6;
        @(negedge clock);
        check("lit_post_rst_drop6", 64'(d_resp_valid), 64'd0);
        cyc(); clr();
        @(negedge clock);
        check("lit_post_rst_err", 64'(tag_error), 64'd1);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
